// File: rtl/usb_rx_nrzi_destuff.sv
// rtl/usb_rx_nrzi_destuff.sv - USB RX NRZI decoder, bit de-stuffer and LSB-first deserialiser.
// Optional stuff-error detection and ERR lock-up enabled by defining RX_DECODER_STUFF_ERR_EN.
module usb_rx_nrzi_destuff #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dplus_in_sync,
  input  logic              shift_enable,
  input  logic              eop,
  output logic              d_orig,
  output logic              bit_valid,
  output logic [DATA_W-1:0] rx_word,
  output logic              word_valid,
  output logic              stuff_err
);

  localparam int              CW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [3:0]      STUFF_MAX = 4'(STUFF_LEN);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_SKIP = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                prev_level_q, prev_level_d;
  logic [3:0]          ones_cnt_q, ones_cnt_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                d_orig_q, d_orig_d;
  logic                bit_valid_q, bit_valid_d;
  logic [DATA_W-1:0]   rx_word_q, rx_word_d;
  logic                word_valid_q, word_valid_d;
  logic                stuff_err_q, stuff_err_d;

  logic                dec;
  logic [3:0]          ones_inc;
  logic [DATA_W-1:0]   shift_next;

  // A line level equal to the previous sample decodes as 1 (no transition).
  assign dec        = (dplus_in_sync == prev_level_q);
  assign ones_inc   = dec ? (ones_cnt_q + 4'd1) : 4'd0;
  assign shift_next = {dec, shift_q[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_DATA;
      prev_level_q <= 1'b1;
      ones_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      d_orig_q     <= 1'b1;
      bit_valid_q  <= 1'b0;
      rx_word_q    <= '0;
      word_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_level_q <= prev_level_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      d_orig_q     <= d_orig_d;
      bit_valid_q  <= bit_valid_d;
      rx_word_q    <= rx_word_d;
      word_valid_q <= word_valid_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (eop) begin
      state_d = ST_DATA;
    end else if (shift_enable) begin
      case (state_q)
        ST_DATA: if (ones_inc == STUFF_MAX) state_d = ST_SKIP;
`ifdef RX_DECODER_STUFF_ERR_EN
        ST_SKIP: state_d = dec ? ST_ERR : ST_DATA;
`else
        ST_SKIP: state_d = ST_DATA;
`endif
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_DATA;
      endcase
    end
  end

  always_comb begin
    prev_level_d = prev_level_q;
    ones_cnt_d   = ones_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    d_orig_d     = d_orig_q;
    bit_valid_d  = 1'b0;
    rx_word_d    = rx_word_q;
    word_valid_d = 1'b0;
    stuff_err_d  = 1'b0;
    if (eop) begin
      // Partial word is discarded; rx_word and d_orig keep their last values.
      prev_level_d = 1'b1;
      ones_cnt_d   = '0;
      bit_cnt_d    = '0;
      shift_d      = '0;
    end else if (shift_enable) begin
      prev_level_d = dplus_in_sync;
      case (state_q)
        ST_DATA: begin
          d_orig_d    = dec;
          bit_valid_d = 1'b1;
          ones_cnt_d  = ones_inc;
          shift_d     = shift_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_word_d    = shift_next;
            word_valid_d = 1'b1;
            bit_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        ST_SKIP: begin
          d_orig_d   = dec;
          ones_cnt_d = '0;
`ifdef RX_DECODER_STUFF_ERR_EN
          stuff_err_d = dec;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign d_orig     = d_orig_q;
  assign bit_valid  = bit_valid_q;
  assign rx_word    = rx_word_q;
  assign word_valid = word_valid_q;
`ifdef RX_DECODER_STUFF_ERR_EN
  assign stuff_err  = stuff_err_q;
`else
  assign stuff_err  = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_nrzi_destuff.sv
// tb/tb_usb_rx_nrzi_destuff.sv - directed table-driven bench for usb_rx_nrzi_destuff.
module tb_usb_rx_nrzi_destuff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dplus_in_sync = 1'b1;
  logic       shift_enable = 1'b0;
  logic       eop = 1'b0;
  logic       d_orig;
  logic       bit_valid;
  logic [7:0] rx_word;
  logic       word_valid;
  logic       stuff_err;

  int checks = 0;
  int errors = 0;

`ifdef RX_DECODER_STUFF_ERR_EN
  localparam logic FEAT = 1'b1;
`else
  localparam logic FEAT = 1'b0;
`endif

  usb_rx_nrzi_destuff #(.DATA_W(8), .STUFF_LEN(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .dplus_in_sync (dplus_in_sync),
    .shift_enable  (shift_enable),
    .eop           (eop),
    .d_orig        (d_orig),
    .bit_valid     (bit_valid),
    .rx_word       (rx_word),
    .word_valid    (word_valid),
    .stuff_err     (stuff_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       se;
    logic       ep;
    logic       line;
    logic       d;
    logic       bv;
    logic       wv;
    logic [7:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic se, input logic ep, input logic line);
    @(negedge clk);
    rst = r;
    shift_enable = se;
    eop = ep;
    dplus_in_sync = line;
    @(posedge clk);
    #1;
    rst = 1'b0;
    shift_enable = 1'b0;
    eop = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic d, input logic bv, input logic wv,
                            input logic se, input logic [7:0] word);
    chk({tag, " d_orig"}, {7'd0, d_orig}, {7'd0, d});
    chk({tag, " bit_valid"}, {7'd0, bit_valid}, {7'd0, bv});
    chk({tag, " word_valid"}, {7'd0, word_valid}, {7'd0, wv});
    chk({tag, " stuff_err"}, {7'd0, stuff_err}, {7'd0, se});
    chk({tag, " rx_word"}, rx_word, word);
  endtask

  // Standard 8-strobe pattern from line-idle (prev=1): seven zeros then a one -> 8'h80.
  task automatic t1_stream(input string tag, input logic [7:0] prev_word, input int gap);
    logic [7:0] lines;
    lines = 8'b0010_1010;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, lines[i]);
      if (i < 7) expect_out($sformatf("%s s%0d", tag, i), 1'b0, 1'b1, 1'b0, 1'b0, prev_word);
      else       expect_out($sformatf("%s s%0d", tag, i), 1'b1, 1'b1, 1'b1, 1'b0, 8'h80);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, lines[i]);
    end
  endtask

  initial begin
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 1, 8'h80});
    // Run of ones continues across the word boundary; stuff bit lands mid next word.
    for (int i = 0; i < 5; i++) vecs.push_back('{0, 1, 0, 0, 1, 1, 0, 8'h80});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 0, 8'h80});
    vecs.push_back('{0, 1, 0, 1, 1, 1, 0, 8'h80});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'h80});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 1, 8'hBF});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 8'hBF});
    vecs.push_back('{0, 0, 1, 0, 1, 0, 0, 8'hBF});
    // Five data bits then eop: partial word dropped.
    vecs.push_back('{0, 1, 0, 1, 1, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 8'hBF});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 8'hBF});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 1, 8'h80});
    vecs.push_back('{0, 0, 1, 0, 1, 0, 0, 8'h80});

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].se, vecs[i].ep, vecs[i].line);
      expect_out($sformatf("row%0d", i), vecs[i].d, vecs[i].bv, vecs[i].wv, 1'b0, vecs[i].word);
    end

    // Stuff bit decoding to 1 (prev=1, ones=0 after the eop above).
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("stf0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      expect_out($sformatf("stf%0d", i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("stf_bit", 1'b1, 1'b0, 1'b0, FEAT, 8'h80);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("stf_clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    if (FEAT) begin
      expect_out("err_ign0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("err_ign1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("err_eop", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
      t1_stream("err_t1", 8'h80, 0);
    end else begin
      expect_out("stf_word", 1'b0, 1'b1, 1'b1, 1'b0, 8'h7E);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Strobes every 8 clocks, reset mid-word, then a fresh word.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, i[0]);
      for (int g = 0; g < 7; g++) step(1'b0, 1'b0, 1'b0, i[0]);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    t1_stream("rst_t1", 8'h00, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("final_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
